// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result-availability scoreboard driving D-stage stalls,
// plus the combinational E/D forwarding selects and a stall-cycle counter.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int MAXLAT = 7,
  parameter int CW     = $clog2(MAXLAT + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_rsD,
  input  logic [AW-1:0] i_rtD,
  input  logic          i_useRsD,
  input  logic          i_useRtD,
  input  logic          i_branchD,
  input  logic          i_regwriteD,
  input  logic [AW-1:0] i_writeregD,
  input  logic [CW-1:0] i_latD,
  input  logic          i_flushD,
  input  logic [AW-1:0] i_rsE,
  input  logic [AW-1:0] i_rtE,
  input  logic [AW-1:0] i_writeregM,
  input  logic [AW-1:0] i_writeregW,
  input  logic          i_regwriteM,
  input  logic          i_regwriteW,
  input  logic          i_clrcnt,
  output logic          o_stallF,
  output logic          o_stallD,
  output logic          o_flushE,
  output logic          o_forwardAD,
  output logic          o_forwardBD,
  output logic [1:0]    o_forwardAE,
  output logic [1:0]    o_forwardBE,
  output logic [31:0]   o_stallcnt
);
  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] w_lat;
  logic          w_raw_a;
  logic          w_raw_b;
  logic          w_waw;
  logic          w_issue;
  // Saturation is only needed when the counter width can hold values above MAXLAT.
  if (((1 << CW) - 1) > MAXLAT) begin : g_sat
    assign w_lat = (i_latD > CW'(MAXLAT)) ? CW'(MAXLAT) : i_latD;
  end else begin : g_nosat
    assign w_lat = i_latD;
  end
  always_comb begin
    w_raw_a     = i_useRsD && i_rsD != '0 &&
                  (i_branchD ? r_cnt[i_rsD] != '0 : r_cnt[i_rsD] >= CW'(2));
    w_raw_b     = i_useRtD && i_rtD != '0 &&
                  (i_branchD ? r_cnt[i_rtD] != '0 : r_cnt[i_rtD] >= CW'(2));
    w_waw       = i_regwriteD && i_writeregD != '0 && r_cnt[i_writeregD] > i_latD;
    o_stallD    = !i_flushD && (w_raw_a || w_raw_b || w_waw);
    o_stallF    = o_stallD;
    o_flushE    = o_stallD;
    w_issue     = i_regwriteD && i_writeregD != '0 && !o_stallD && !i_flushD;
    o_forwardAE = (i_rsE != '0 && i_rsE == i_writeregM && i_regwriteM) ? 2'b10 :
                  (i_rsE != '0 && i_rsE == i_writeregW && i_regwriteW) ? 2'b01 : 2'b00;
    o_forwardBE = (i_rtE != '0 && i_rtE == i_writeregM && i_regwriteM) ? 2'b10 :
                  (i_rtE != '0 && i_rtE == i_writeregW && i_regwriteW) ? 2'b01 : 2'b00;
    o_forwardAD = i_rsD != '0 && i_rsD == i_writeregM && i_regwriteM;
    o_forwardBD = i_rtD != '0 && i_rtD == i_writeregM && i_regwriteM;
  end
  // Entry 0 is only ever reset, so it stays zero.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    else
      for (int i = 1; i < NREG; i++)
        r_cnt[i] <= (w_issue && i_writeregD == AW'(i)) ? w_lat :
                    (r_cnt[i] != '0) ? r_cnt[i] - 1'b1 : '0;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) o_stallcnt <= '0;
    else if (i_clrcnt) o_stallcnt <= '0;
    else if (o_stallD) o_stallcnt <= o_stallcnt + 32'd1;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: per-cycle vector table for stall/forward behaviour plus
// hand sequences for long-op stall counting, clrcnt and asynchronous reset.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rsD = '0, rtD = '0, writeregD = '0, rsE = '0, rtE = '0, writeregM = '0, writeregW = '0;
  logic        useRsD = 1'b0, useRtD = 1'b0, branchD = 1'b0, regwriteD = 1'b0, flushD = 1'b0;
  logic        regwriteM = 1'b0, regwriteW = 1'b0, clrcnt = 1'b0;
  logic [2:0]  latD = '0;
  logic        stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stallcnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int rs, rt, urs, urt, br, rw, wr, lat, fl;
    int rse, rte, wm, ww, rwm, rww;
    int st, fad, fbd, fae, fbe;
  } vec_t;

  hazard_scoreboard dut (
    .i_clk(clk), .i_reset(reset), .i_rsD(rsD), .i_rtD(rtD), .i_useRsD(useRsD), .i_useRtD(useRtD),
    .i_branchD(branchD), .i_regwriteD(regwriteD), .i_writeregD(writeregD), .i_latD(latD),
    .i_flushD(flushD), .i_rsE(rsE), .i_rtE(rtE), .i_writeregM(writeregM), .i_writeregW(writeregW),
    .i_regwriteM(regwriteM), .i_regwriteW(regwriteW), .i_clrcnt(clrcnt), .o_stallF(stallF),
    .o_stallD(stallD), .o_flushE(flushE), .o_forwardAD(forwardAD), .o_forwardBD(forwardBD),
    .o_forwardAE(forwardAE), .o_forwardBE(forwardBE), .o_stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rsD = 5'(v.rs); rtD = 5'(v.rt); useRsD = v.urs[0]; useRtD = v.urt[0]; branchD = v.br[0];
    regwriteD = v.rw[0]; writeregD = 5'(v.wr); latD = 3'(v.lat); flushD = v.fl[0];
    rsE = 5'(v.rse); rtE = 5'(v.rte); writeregM = 5'(v.wm); writeregW = 5'(v.ww);
    regwriteM = v.rwm[0]; regwriteW = v.rww[0];
  endtask

  vec_t tbl [27];
  vec_t idle;

  initial begin
    idle = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[0]  = '{0,0,0,0,0,1,5,1,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[1]  = '{5,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[2]  = '{5,0,1,0,1,0,0,0,0, 0,0,5,0,1,0, 0,1,0,0,0};
    tbl[3]  = '{0,0,0,0,0,1,8,2,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[4]  = '{0,8,0,1,0,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[5]  = '{0,8,0,1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[6]  = '{0,0,0,0,0,1,8,2,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[7]  = '{8,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[8]  = '{8,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[9]  = '{8,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[10] = '{0,0,0,0,0,1,3,4,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[11] = '{0,0,0,0,0,1,3,1,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[12] = '{0,0,0,0,0,1,3,1,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[13] = '{0,0,0,0,0,1,3,1,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[14] = '{0,0,0,0,0,1,3,1,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[15] = '{3,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0};
    tbl[16] = '{3,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[17] = '{0,0,0,0,0,1,0,7,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[18] = '{0,0,1,1,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[19] = '{0,0,0,0,0,1,9,3,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[20] = '{9,0,1,0,0,1,10,5,1, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[21] = '{10,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[22] = '{0,0,0,0,0,1,11,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[23] = '{11,0,1,0,1,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0};
    tbl[24] = '{0,0,0,0,0,0,0,0,0, 4,6,4,4,1,1, 0,0,0,2,0};
    tbl[25] = '{0,0,0,0,0,0,0,0,0, 4,6,6,4,1,1, 0,0,0,1,2};
    tbl[26] = '{0,7,0,0,0,0,0,0,0, 0,7,7,0,1,1, 0,0,1,0,2};

    drive(idle);
    tick();
    chk("reset_stallD", stallD, 0);
    chk("reset_stallcnt", stallcnt, 0);
    chk("reset_fwdAE", forwardAE, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("v%0d_stallD", i), stallD, tbl[i].st);
      chk($sformatf("v%0d_stallF", i), stallF, tbl[i].st);
      chk($sformatf("v%0d_flushE", i), flushE, tbl[i].st);
      chk($sformatf("v%0d_fwdAD", i), forwardAD, tbl[i].fad);
      chk($sformatf("v%0d_fwdBD", i), forwardBD, tbl[i].fbd);
      chk($sformatf("v%0d_fwdAE", i), forwardAE, tbl[i].fae);
      chk($sformatf("v%0d_fwdBE", i), forwardBE, tbl[i].fbe);
      tick();
    end

    drive(idle);
    clrcnt = 1'b1;
    tick();
    clrcnt = 1'b0;
    chk("clr_before_long", stallcnt, 0);
    regwriteD = 1'b1; writeregD = 5'd3; latD = 3'd6;
    #3;
    chk("long_issue_stall", stallD, 0);
    tick();
    drive(idle);
    rsD = 5'd3; useRsD = 1'b1;
    begin
      int n = 0;
      #3;
      while (stallD && n < 20) begin
        tick();
        #3;
        n++;
      end
      chk("long_stall_cycles", n, 5);
    end
    chk("long_stallcnt", stallcnt, 5);
    tick();
    drive(idle);
    clrcnt = 1'b1;
    tick();
    clrcnt = 1'b0;
    chk("clrcnt_zero", stallcnt, 0);

    regwriteD = 1'b1; writeregD = 5'd5; latD = 3'd3;
    tick();
    drive(idle);
    rsD = 5'd5; useRsD = 1'b1;
    #3;
    chk("ar_pre_stall0", stallD, 1);
    tick();
    chk("ar_pre_stall1", stallD, 1);
    chk("ar_pre_cnt", stallcnt, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_stallD", stallD, 0);
    chk("ar_stallF", stallF, 0);
    chk("ar_stallcnt", stallcnt, 0);
    reset = 1'b0;
    #1;
    chk("ar_after_stall", stallD, 0);
    tick();
    chk("ar_next_stall", stallD, 0);
    chk("ar_next_cnt", stallcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
